// File: rtl/sram_arbiter_pkg.sv
// Shared widths, RAM op codes, FSM states and grant encoding for the SRAM arbiter.
package sram_arbiter_pkg;

    localparam int ADDR_BUS = 18;
    localparam int DATA_BUS = 16;

    localparam logic RAM_OP_RD = 1'b0;
    localparam logic RAM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM-controller signals around the arbiter.
interface sram_arbiter_if;
    import sram_arbiter_pkg::*;

    logic                if_req;
    logic [ADDR_BUS-1:0] if_addr;
    logic [DATA_BUS-1:0] if_rdata;
    logic                if_ack;

    logic                mem_req;
    logic                mem_op;
    logic [ADDR_BUS-1:0] mem_addr;
    logic [DATA_BUS-1:0] mem_wdata;
    logic [DATA_BUS-1:0] mem_rdata;
    logic                mem_ack;

    logic                ram_en;
    logic                ram_op;
    logic [ADDR_BUS-1:0] ram_addr;
    logic [DATA_BUS-1:0] ram_wdata;
    logic [DATA_BUS-1:0] ram_rdata;

    logic                stall;

    // master is everything around the arbiter: both requesters and the controller read data
    modport master (
        output if_req, if_addr, mem_req, mem_op, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_op, ram_addr, ram_wdata, stall
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_op, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_op, ram_addr, ram_wdata, stall
    );

endinterface

// File: rtl/sram_arbiter_pick.sv
// Grant selection between fetch and data ports; SRAM_ARB_RR_EN selects round-robin,
// otherwise the data port has fixed priority.
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
`ifdef SRAM_ARB_RR_EN
    input  gnt_t last_gnt,
`endif
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_IF;
`ifdef SRAM_ARB_RR_EN
        if (if_req && mem_req)
            gnt = (last_gnt == GNT_MEM) ? GNT_IF : GNT_MEM;
        else if (mem_req)
            gnt = GNT_MEM;
`else
        if (mem_req)
            gnt = GNT_MEM;
`endif
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-access SRAM controller (4-cycle access).
// SRAM_ARB_RR_EN switches contention from fixed mem priority to round-robin.
//
// state | meaning
// IDLE  | sample requests, latch grant/addr/op/wdata, pulse ram_en
// ACC1  | ram_en high, controller samples the access
// ACC2  | controller completion cycle, rdata captured at the end
// RESP  | ack high for one cycle to the granted port
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic          clk_50MHz,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    arb_state_t          state_q, state_d;
    gnt_t                gnt_sel, gnt_q;
    logic                load, capture;
    logic                ram_en_q, ram_op_q;
    logic [ADDR_BUS-1:0] ram_addr_q;
    logic [DATA_BUS-1:0] ram_wdata_q, if_rdata_q, mem_rdata_q;
    logic                if_ack_q, mem_ack_q;

    sram_arb_pick u_pick (
        .if_req   (bus.if_req),
        .mem_req  (bus.mem_req),
`ifdef SRAM_ARB_RR_EN
        .last_gnt (gnt_q),
`endif
        .gnt      (gnt_sel)
    );

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    state_d = ACC1;
                    load    = 1'b1;
                end
            end
            ACC1: state_d = ACC2;
            ACC2: begin
                state_d = RESP;
                capture = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // gnt_q doubles as the last-grant flag for round-robin
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            gnt_q       <= GNT_IF;
            ram_en_q    <= 1'b0;
            ram_op_q    <= RAM_OP_RD;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            ram_en_q  <= load;
            if_ack_q  <= capture && (gnt_q == GNT_IF);
            mem_ack_q <= capture && (gnt_q == GNT_MEM);
            if (load) begin
                gnt_q <= gnt_sel;
                if (gnt_sel == GNT_MEM) begin
                    ram_addr_q  <= bus.mem_addr;
                    ram_op_q    <= bus.mem_op;
                    ram_wdata_q <= bus.mem_wdata;
                end else begin
                    ram_addr_q  <= bus.if_addr;
                    ram_op_q    <= RAM_OP_RD;
                    ram_wdata_q <= '0;
                end
            end
            if (capture && (ram_op_q == RAM_OP_RD)) begin
                if (gnt_q == GNT_MEM) mem_rdata_q <= bus.ram_rdata;
                else                  if_rdata_q  <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_op    = ram_op_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table of single accesses plus contention, reset-abort
// and back-to-back sequences, with a scoreboard of expected completions.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    logic clk_50MHz = 1'b0;
    logic rst       = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    sram_arbiter_if bus();

    sram_arbiter dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'h5A5A ^ {14'b0, a[17:16]};
    endfunction

    // controller model: samples on ram_en, data valid in the following cycle
    logic [15:0] sram [logic [17:0]];
    always @(posedge clk_50MHz) begin
        if (bus.ram_en) begin
            if (bus.ram_op == RAM_OP_WR) sram[bus.ram_addr] = bus.ram_wdata;
            else bus.ram_rdata <= sram.exists(bus.ram_addr) ? sram[bus.ram_addr] : pat(bus.ram_addr);
        end
    end

    typedef struct {
        logic        is_mem;
        logic        is_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [15:0] exp_if_rd  = '0;
    logic [15:0] exp_mem_rd = '0;
    logic        prev_en    = 1'b0;

    always @(negedge clk_50MHz) begin
        if (!rst) begin
            sb.delete();
            exp_if_rd  = '0;
            exp_mem_rd = '0;
            prev_en    = 1'b0;
        end else begin
            if (bus.ram_en) chk("ram_en_single_cycle", 32'(prev_en), 32'(0));
            if (bus.if_ack || bus.mem_ack) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: if_ack=%b mem_ack=%b, none expected at %0t",
                             bus.if_ack, bus.mem_ack, $time);
                end else begin
                    e_mon = sb.pop_front();
                    chk("ack_port", 32'(bus.mem_ack), 32'(e_mon.is_mem));
                    chk("ack_exclusive", 32'(bus.if_ack & bus.mem_ack), 32'(0));
                    if (e_mon.is_rd) begin
                        if (e_mon.is_mem) exp_mem_rd = e_mon.rdata;
                        else              exp_if_rd  = e_mon.rdata;
                    end
                    chk("if_rdata", 32'(bus.if_rdata), 32'(exp_if_rd));
                    chk("mem_rdata", 32'(bus.mem_rdata), 32'(exp_mem_rd));
                end
            end
            prev_en = bus.ram_en;
        end
    end

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_op    = RAM_OP_RD;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic access(input logic is_mem, input logic op, input logic [17:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd);
        @(negedge clk_50MHz);
        if (is_mem) begin
            bus.mem_req   = 1'b1;
            bus.mem_op    = op;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
            bus.mem_op  = RAM_OP_WR;
        end
        sb.push_back('{is_mem: is_mem, is_rd: (!is_mem || op == RAM_OP_RD), rdata: exp_rd});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_50MHz);
            chk("ram_en_timing", 32'(bus.ram_en), 32'(k == 1));
            chk("ram_addr", 32'(bus.ram_addr), 32'(addr));
            chk("ram_op", 32'(bus.ram_op), 32'(is_mem ? op : RAM_OP_RD));
            if (is_mem && op == RAM_OP_WR) chk("ram_wdata", 32'(bus.ram_wdata), 32'(wdata));
            chk("ack_latency", 32'(is_mem ? bus.mem_ack : bus.if_ack), 32'(k == 3));
            chk("stall", 32'(bus.stall), 32'(k != 3));
        end
        idle_inputs();
    endtask

    typedef struct {
        logic        is_mem;
        logic        op;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        sram[18'h00010] = 16'hBEEF;

        vt[0] = '{1'b1, RAM_OP_RD, 18'h00010, 16'h0000, 16'hBEEF};
        vt[1] = '{1'b1, RAM_OP_WR, 18'h3FFFF, 16'hA5A5, 16'h0000};
        vt[2] = '{1'b0, RAM_OP_RD, 18'h3FFFF, 16'h0000, 16'hA5A5};
        vt[3] = '{1'b1, RAM_OP_RD, 18'h00005, 16'h0000, pat(18'h00005)};
        vt[4] = '{1'b0, RAM_OP_RD, 18'h2AAAA, 16'h0000, pat(18'h2AAAA)};
        vt[5] = '{1'b1, RAM_OP_WR, 18'h00020, 16'h1234, 16'h0000};
        vt[6] = '{1'b1, RAM_OP_RD, 18'h00020, 16'h0000, 16'h1234};
        vt[7] = '{1'b0, RAM_OP_RD, 18'h15555, 16'h0000, pat(18'h15555)};
        vt[8] = '{1'b1, RAM_OP_RD, 18'h00000, 16'h0000, 16'h5A5A};

        // reset values
        #5;
        chk("rst_ram_en", 32'(bus.ram_en), 32'(0));
        chk("rst_ram_op", 32'(bus.ram_op), 32'(RAM_OP_RD));
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'(0));
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'(0));
        chk("rst_acks", 32'({bus.if_ack, bus.mem_ack}), 32'(0));
        chk("rst_if_rdata", 32'(bus.if_rdata), 32'(0));
        chk("rst_mem_rdata", 32'(bus.mem_rdata), 32'(0));
        chk("rst_stall", 32'(bus.stall), 32'(0));
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b1;

        foreach (vt[i])
            access(vt[i].is_mem, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].exp_rd);

        // contention: both ports request in the same IDLE cycle
        @(negedge clk_50MHz);
        bus.if_req   = 1'b1;
        bus.if_addr  = 18'h00100;
        bus.mem_req  = 1'b1;
        bus.mem_op   = RAM_OP_RD;
        bus.mem_addr = 18'h00200;
`ifdef SRAM_ARB_RR_EN
        for (int n = 0; n < 2; n++) begin
            sb.push_back('{is_mem: 1'b1, is_rd: 1'b1, rdata: pat(18'h00200)});
            sb.push_back('{is_mem: 1'b0, is_rd: 1'b1, rdata: pat(18'h00100)});
        end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_50MHz);
            chk("rr_mem_ack", 32'(bus.mem_ack), 32'(k == 3 || k == 11));
            chk("rr_if_ack", 32'(bus.if_ack), 32'(k == 7 || k == 15));
            chk("rr_stall", 32'(bus.stall), 32'(1));
        end
`else
        sb.push_back('{is_mem: 1'b1, is_rd: 1'b1, rdata: pat(18'h00200)});
        sb.push_back('{is_mem: 1'b0, is_rd: 1'b1, rdata: pat(18'h00100)});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_50MHz);
            chk("fix_mem_ack", 32'(bus.mem_ack), 32'(k == 3));
            chk("fix_if_ack", 32'(bus.if_ack), 32'(k == 7));
            chk("fix_stall", 32'(bus.stall), 32'(k != 7));
            if (k == 3) bus.mem_req = 1'b0;
        end
`endif
        idle_inputs();
        repeat (4) @(negedge clk_50MHz);

        // back-to-back fetches with if_req held high
        @(negedge clk_50MHz);
        bus.if_req  = 1'b1;
        bus.if_addr = 18'h00000;
        for (int n = 0; n < 3; n++)
            sb.push_back('{is_mem: 1'b0, is_rd: 1'b1, rdata: pat(18'(n))});
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_50MHz);
            chk("b2b_if_ack", 32'(bus.if_ack), 32'(k % 4 == 3));
            if (k % 4 == 1) chk("b2b_ram_addr", 32'(bus.ram_addr), 32'((k - 1) / 4));
            if (k == 3) bus.if_addr = 18'h00001;
            if (k == 7) bus.if_addr = 18'h00002;
        end
        idle_inputs();
        repeat (2) @(negedge clk_50MHz);

        // reset during ACC2 aborts the access
        @(negedge clk_50MHz);
        bus.mem_req  = 1'b1;
        bus.mem_op   = RAM_OP_RD;
        bus.mem_addr = 18'h00010;
        @(negedge clk_50MHz);
        chk("abort_acc1_en", 32'(bus.ram_en), 32'(1));
        @(negedge clk_50MHz);
        #2 rst = 1'b0;
        #1;
        chk("abort_ram_en", 32'(bus.ram_en), 32'(0));
        chk("abort_ram_addr", 32'(bus.ram_addr), 32'(0));
        chk("abort_mem_ack", 32'(bus.mem_ack), 32'(0));
        chk("abort_mem_rdata", 32'(bus.mem_rdata), 32'(0));
        chk("abort_if_rdata", 32'(bus.if_rdata), 32'(0));
        idle_inputs();
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_50MHz);
            chk("post_abort_ack", 32'({bus.if_ack, bus.mem_ack}), 32'(0));
            chk("post_abort_rdata", 32'(bus.mem_rdata), 32'(0));
        end
        access(1'b1, RAM_OP_RD, 18'h00010, 16'h0000, 16'hBEEF);

        repeat (4) @(negedge clk_50MHz);
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
